// File: rtl/cr16_psr_cond.sv
// CR16 processor status register with in-flight flag tracking and a
// one-deep condition-code evaluator behind a valid/ready handshake.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no result held; a request is accepted whenever flags are final
// RESP   | result presented on O_TAKEN; can hand off and accept same cycle
module cr16_psr_cond #(
  parameter logic [4:0]  PSR_RESET   = 5'b00000,
  parameter int unsigned MAX_PENDING = 3
) (
  input  logic       I_CLK,
  input  logic       I_NRESET,
  input  logic       I_ALU_ISSUE,
  input  logic       I_ALU_VALID,
  input  logic [4:0] I_ALU_STATUS,
  input  logic [4:0] I_FLAG_MASK,
  input  logic       I_PSR_WE,
  input  logic [4:0] I_PSR_WDATA,
  output logic [4:0] O_PSR,
  input  logic       I_COND_VALID,
  input  logic [3:0] I_COND,
  output logic       O_COND_READY,
  output logic       O_TAKEN_VALID,
  output logic       O_TAKEN,
  input  logic       I_TAKEN_READY,
  output logic       O_ERROR
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RESP = 1'b1
  } state_t;

  localparam logic [1:0] PEND_MAX = 2'(MAX_PENDING);

  // Flag bit positions inside the PSR
  localparam int C_BIT = 0;
  localparam int L_BIT = 1;
  localparam int F_BIT = 2;
  localparam int Z_BIT = 3;
  localparam int N_BIT = 4;

  state_t     state_q, state_d;
  logic [4:0] psr_q, psr_next;
  logic [1:0] pending_q, pending_d;
  logic       error_q, error_set;
  logic       taken_q, taken_d;
  logic       flags_ok;
  logic       cond_ready;
  logic       accept;

  function automatic logic cond_eval(input logic [3:0] code, input logic [4:0] psr);
    logic c, l, f, z, n;
    c = psr[C_BIT];
    l = psr[L_BIT];
    f = psr[F_BIT];
    z = psr[Z_BIT];
    n = psr[N_BIT];
    case (code)
      4'd0:    cond_eval = z;
      4'd1:    cond_eval = !z;
      4'd2:    cond_eval = c;
      4'd3:    cond_eval = !c;
      4'd4:    cond_eval = l;
      4'd5:    cond_eval = !l;
      4'd6:    cond_eval = n;
      4'd7:    cond_eval = !n;
      4'd8:    cond_eval = f;
      4'd9:    cond_eval = !f;
      4'd10:   cond_eval = !l && !z;
      4'd11:   cond_eval = l || z;
      4'd12:   cond_eval = !n && !z;
      4'd13:   cond_eval = n || z;
      4'd14:   cond_eval = 1'b1;
      default: cond_eval = 1'b0;
    endcase
  endfunction

  // Next PSR: explicit load wins, otherwise masked merge of ALU flags
  always_comb begin
    psr_next = psr_q;
    if (I_PSR_WE) begin
      psr_next = I_PSR_WDATA;
    end else if (I_ALU_VALID) begin
      psr_next = (psr_q & ~I_FLAG_MASK) | (I_ALU_STATUS & I_FLAG_MASK);
    end
  end

  // In-flight counter with saturation; over/underflow raise the error
  always_comb begin
    pending_d = pending_q;
    error_set = 1'b0;
    if (I_ALU_ISSUE && !I_ALU_VALID) begin
      if (pending_q == PEND_MAX) error_set = 1'b1;
      else                       pending_d = pending_q + 2'd1;
    end else if (I_ALU_VALID && !I_ALU_ISSUE) begin
      if (pending_q == 2'd0) error_set = 1'b1;
      else                   pending_d = pending_q - 2'd1;
    end
  end

  // Flags are final when nothing is in flight, or the last op lands now
  // (its flags are forwarded through psr_next). A same-cycle issue is
  // ordered after the branch, so it is ignored here.
  assign flags_ok = (pending_q == 2'd0) || ((pending_q == 2'd1) && I_ALU_VALID);

  // Handshake FSM: ready, accept, next state and the captured result
  always_comb begin
    state_d    = state_q;
    taken_d    = taken_q;
    cond_ready = flags_ok;
    if (state_q == S_RESP) cond_ready = flags_ok && I_TAKEN_READY;
    accept = I_COND_VALID && cond_ready;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_RESP;
      end
      S_RESP: begin
        if (I_TAKEN_READY && !accept) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (accept) taken_d = cond_eval(I_COND, psr_next);
  end

  // State and datapath registers
  always_ff @(posedge I_CLK or negedge I_NRESET) begin
    if (!I_NRESET) begin
      state_q   <= S_IDLE;
      psr_q     <= PSR_RESET;
      pending_q <= 2'd0;
      error_q   <= 1'b0;
      taken_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      psr_q     <= psr_next;
      pending_q <= pending_d;
      error_q   <= error_q | error_set;
      taken_q   <= taken_d;
    end
  end

  assign O_PSR         = psr_q;
  assign O_COND_READY  = cond_ready;
  assign O_TAKEN_VALID = (state_q == S_RESP);
  assign O_TAKEN       = taken_q;
  assign O_ERROR       = error_q;

endmodule

// File: tb/tb_cr16_psr_cond.sv
// Directed plus randomized bench for cr16_psr_cond against a behavioural model.
module tb_cr16_psr_cond;

  logic       clk;
  logic       nreset;
  logic       alu_issue;
  logic       alu_valid;
  logic [4:0] alu_status;
  logic [4:0] flag_mask;
  logic       psr_we;
  logic [4:0] psr_wdata;
  logic [4:0] psr;
  logic       cond_valid;
  logic [3:0] cond;
  logic       cond_ready;
  logic       taken_valid;
  logic       taken;
  logic       taken_ready;
  logic       error;

  int errors = 0;
  int checks = 0;

  // Behavioural model state
  logic [4:0] m_psr;
  int         m_pend;
  bit         m_resp;
  logic       m_taken;
  logic       m_err;
  logic       last_ready;

  cr16_psr_cond #(.PSR_RESET(5'b00000), .MAX_PENDING(3)) dut (
    .I_CLK         (clk),
    .I_NRESET      (nreset),
    .I_ALU_ISSUE   (alu_issue),
    .I_ALU_VALID   (alu_valid),
    .I_ALU_STATUS  (alu_status),
    .I_FLAG_MASK   (flag_mask),
    .I_PSR_WE      (psr_we),
    .I_PSR_WDATA   (psr_wdata),
    .O_PSR         (psr),
    .I_COND_VALID  (cond_valid),
    .I_COND        (cond),
    .O_COND_READY  (cond_ready),
    .O_TAKEN_VALID (taken_valid),
    .O_TAKEN       (taken),
    .I_TAKEN_READY (taken_ready),
    .O_ERROR       (error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [4:0] obs, input logic [4:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  // Codes 0..9 are flag/inverted-flag pairs (Z,C,L,N,F); 10..13 are
  // inverted/plain pairs of L|Z and N|Z; 14 always, 15 never.
  function automatic logic ref_cond(input int code, input logic [4:0] p);
    int   pair_bit[5];
    logic v;
    pair_bit = '{3, 0, 1, 4, 2};
    if (code < 10) return p[pair_bit[code / 2]] ^ (code % 2 == 1);
    if (code < 12) v = p[1] | p[3];
    else if (code < 14) v = p[4] | p[3];
    else return code == 14;
    return (code % 2 == 1) ? v : !v;
  endfunction

  task automatic idle_inputs();
    alu_issue   = 1'b0;
    alu_valid   = 1'b0;
    alu_status  = 5'b0;
    flag_mask   = 5'b0;
    psr_we      = 1'b0;
    psr_wdata   = 5'b0;
    cond_valid  = 1'b0;
    cond        = 4'd0;
    taken_ready = 1'b1;
  endtask

  task automatic model_reset();
    m_psr   = 5'b00000;
    m_pend  = 0;
    m_resp  = 1'b0;
    m_taken = 1'b0;
    m_err   = 1'b0;
  endtask

  // Called at posedge+1 with inputs already driven; returns at next posedge+1
  task automatic step();
    logic       fok, rdy, acc;
    logic [4:0] pn;
    #3;
    fok = (m_pend == 0) || (m_pend == 1 && alu_valid);
    rdy = m_resp ? (fok && taken_ready) : fok;
    last_ready = cond_ready;
    chk("cond_ready", 5'(cond_ready), 5'(rdy));
    acc = cond_valid && rdy;
    pn = m_psr;
    if (psr_we) pn = psr_wdata;
    else if (alu_valid)
      for (int k = 0; k < 5; k++) if (flag_mask[k]) pn[k] = alu_status[k];
    if (alu_issue && !alu_valid) begin
      if (m_pend == 3) m_err = 1'b1; else m_pend++;
    end else if (alu_valid && !alu_issue) begin
      if (m_pend == 0) m_err = 1'b1; else m_pend--;
    end
    if (acc) m_taken = ref_cond(int'(cond), pn);
    m_resp = acc || (m_resp && !taken_ready);
    m_psr  = pn;
    @(posedge clk);
    #1;
    chk("psr", psr, m_psr);
    chk("taken_valid", 5'(taken_valid), 5'(m_resp));
    chk("taken", 5'(taken), 5'(m_taken));
    chk("error", 5'(error), 5'(m_err));
    idle_inputs();
  endtask

  // Asynchronous reset pulse from posedge+1, checked before any clock edge
  task automatic reset_pulse();
    nreset = 1'b0;
    #1;
    model_reset();
    chk("rst_taken_valid", 5'(taken_valid), 5'b0);
    chk("rst_psr", psr, 5'b00000);
    chk("rst_error", 5'(error), 5'b0);
    chk("rst_cond_ready", 5'(cond_ready), 5'b1);
    #2;
    nreset = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_taken_valid", 5'(taken_valid), 5'b0);
  endtask

  initial begin
    idle_inputs();
    model_reset();
    nreset = 1'b0;
    #2;
    chk("reset_psr", psr, 5'b00000);
    chk("reset_taken_valid", 5'(taken_valid), 5'b0);
    chk("reset_taken", 5'(taken), 5'b0);
    chk("reset_error", 5'(error), 5'b0);
    chk("reset_cond_ready", 5'(cond_ready), 5'b1);
    #10;
    nreset = 1'b1;
    @(posedge clk);
    #1;

    // Explicit load, then EQ/NE/UC/NV back to back
    psr_we = 1'b1; psr_wdata = 5'b01000; step();
    chk("lpr_psr", psr, 5'b01000);
    cond_valid = 1'b1; cond = 4'd0; step();
    chk("eq_taken", 5'({taken_valid, taken}), 5'b11);
    cond_valid = 1'b1; cond = 4'd1; step();
    chk("ne_taken", 5'(taken), 5'b0);
    cond_valid = 1'b1; cond = 4'd14; step();
    chk("uc_taken", 5'(taken), 5'b1);
    cond_valid = 1'b1; cond = 4'd15; step();
    chk("nv_taken", 5'(taken), 5'b0);
    step();

    // Masked ALU update and load priority
    psr_we = 1'b1; psr_wdata = 5'b11111; step();
    alu_issue = 1'b1; step();
    alu_valid = 1'b1; alu_status = 5'b00000; flag_mask = 5'b00101; step();
    chk("mask_psr", psr, 5'b11010);
    alu_issue = 1'b1; step();
    alu_valid = 1'b1; alu_status = 5'b00000; flag_mask = 5'b11111;
    psr_we = 1'b1; psr_wdata = 5'b00001; step();
    chk("we_priority_psr", psr, 5'b00001);

    // Hazard with forwarding of Z in the landing cycle
    alu_issue = 1'b1; step();
    cond_valid = 1'b1; cond = 4'd0; step();
    chk("hazard_blocked", 5'(last_ready), 5'b0);
    cond_valid = 1'b1; cond = 4'd0;
    alu_valid = 1'b1; alu_status = 5'b01000; flag_mask = 5'b01000; step();
    chk("hazard_accept", 5'(last_ready), 5'b1);
    chk("hazard_fwd_taken", 5'({taken_valid, taken}), 5'b11);
    step();

    // Backpressure: held result survives PSR writes, then back-to-back GE
    psr_we = 1'b1; psr_wdata = 5'b00000; step();
    cond_valid = 1'b1; cond = 4'd12; step();
    chk("lt_taken", 5'(taken), 5'b1);
    for (int i = 0; i < 3; i++) begin
      taken_ready = 1'b0; cond_valid = 1'b1; cond = 4'd13;
      psr_we = 1'b1; psr_wdata = 5'b10000; step();
      chk("stall_ready", 5'(last_ready), 5'b0);
      chk("stall_taken", 5'({taken_valid, taken}), 5'b11);
    end
    taken_ready = 1'b1; cond_valid = 1'b1; cond = 4'd13; step();
    chk("b2b_ready", 5'(last_ready), 5'b1);
    chk("ge_taken", 5'({taken_valid, taken}), 5'b11);
    step();

    // Underflow error still updates the PSR; overflow saturates
    alu_valid = 1'b1; alu_status = 5'b10101; flag_mask = 5'b11111; step();
    chk("underflow_error", 5'(error), 5'b1);
    chk("underflow_psr", psr, 5'b10101);
    for (int i = 0; i < 4; i++) begin
      alu_issue = 1'b1; step();
    end
    chk("overflow_error", 5'(error), 5'b1);
    cond_valid = 1'b1; cond = 4'd14; step();
    chk("sat_blocked", 5'(last_ready), 5'b0);
    for (int i = 0; i < 3; i++) begin
      alu_valid = 1'b1; step();
    end
    cond_valid = 1'b1; cond = 4'd14; step();
    chk("drained_accept", 5'(last_ready), 5'b1);

    // Reset while a result is outstanding
    cond_valid = 1'b1; cond = 4'd14; taken_ready = 1'b0; step();
    chk("pre_rst_taken_valid", 5'(taken_valid), 5'b1);
    reset_pulse();

    // Randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      alu_issue   = ($urandom_range(0, 9) < 3);
      alu_valid   = (m_pend > 0) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 39) == 0);
      alu_status  = 5'($urandom);
      flag_mask   = 5'($urandom);
      psr_we      = ($urandom_range(0, 9) == 0);
      psr_wdata   = 5'($urandom);
      cond_valid  = ($urandom_range(0, 2) != 0);
      cond        = 4'($urandom);
      taken_ready = ($urandom_range(0, 3) != 0);
      step();
      if (i == 300) reset_pulse();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cr16_psr_cond.md
# cr16_psr_cond

Processor status register and branch-condition resolver for the CR16 datapath. Captures the 5-bit flag vector produced by `cr16_alu` (C, L, F, Z, N) under a per-operation write mask. Tracks ALU operations still in flight and evaluates the 16 CR16 condition codes for branch/jump requests through a valid/ready handshake. Sits between the ALU status output and the fetch/branch control unit.

## Interface
Parameters:
- `PSR_RESET`, 5'b00000: PSR value after reset.
- `MAX_PENDING`, 3: maximum outstanding flag-writing ALU ops (2-bit counter).

Ports:
- `I_CLK`  in  1  clock, all state on rising edge.
- `I_NRESET`  in  1  asynchronous, active-low reset.
- `I_ALU_ISSUE`  in  1  a flag-writing ALU op was issued this cycle.
- `I_ALU_VALID`  in  1  ALU status for the oldest issued op is present this cycle.
- `I_ALU_STATUS`  in  5  ALU flags: [0]C [1]L [2]F [3]Z [4]N.
- `I_FLAG_MASK`  in  5  per-bit write enable for `I_ALU_STATUS`, same encoding.
- `I_PSR_WE`  in  1  explicit PSR load (LPR).
- `I_PSR_WDATA`  in  5  value for explicit load.
- `O_PSR`  out  5  current PSR.
- `I_COND_VALID`  in  1  condition evaluation request.
- `I_COND`  in  4  CR16 condition code.
- `O_COND_READY`  out  1  request accepted when high with `I_COND_VALID`.
- `O_TAKEN_VALID`  out  1  result valid.
- `O_TAKEN`  out  1  condition true.
- `I_TAKEN_READY`  in  1  consumer accepts result.
- `O_ERROR`  out  1  sticky protocol error.

## Operation
- PSR next value (`psr_next`):
  - `I_PSR_WE` has priority and loads `I_PSR_WDATA` in full.
  - Else, when `I_ALU_VALID` is high, each bit k takes `I_ALU_STATUS[k]` if `I_FLAG_MASK[k]`, otherwise it holds.
  - Else the PSR holds.
- Pending counter:
  - +1 on `I_ALU_ISSUE` alone; -1 on `I_ALU_VALID` alone; unchanged when both are high.
  - Saturates at `MAX_PENDING` and at 0.
  - Issue while at `MAX_PENDING` with no simultaneous valid sets `O_ERROR`.
  - `I_ALU_VALID` while at 0 with no simultaneous issue sets `O_ERROR`. The PSR update is still applied.
- Hazard: `flags_ok` = (pending==0) or (pending==1 and `I_ALU_VALID`). An issue in the same cycle as a request does not block it; the branch is ordered before that op.
- FSM:
  - IDLE: `O_COND_READY` = `flags_ok`.
  - RESP: `O_TAKEN_VALID`=1 and `O_COND_READY` = `flags_ok & I_TAKEN_READY`.
  - Transitions:
    - IDLE to RESP on accept.
    - RESP to IDLE when `I_TAKEN_READY` is high and there is no new accept.
    - RESP stays in RESP on stall, or on an accept in the same cycle as the handoff.
- Evaluation: on accept, `O_TAKEN` registers cond(`I_COND`, `psr_next`), so flags written in the accept cycle are visible. `O_TAKEN` is held stable while stalled.
- Condition codes:
  - 0 EQ: Z
  - 1 NE: !Z
  - 2 CS: C
  - 3 CC: !C
  - 4 HI: L
  - 5 LS: !L
  - 6 GT: N
  - 7 LE: !N
  - 8 FS: F
  - 9 FC: !F
  - 10 LO: !L&!Z
  - 11 HS: L|Z
  - 12 LT: !N&!Z
  - 13 GE: N|Z
  - 14 UC: 1
  - 15 NV: 0
- `O_ERROR` is cleared only by reset.

## Timing
- Reset values:
  - `O_PSR`=`PSR_RESET`, pending=0, state IDLE.
  - `O_TAKEN_VALID`=0, `O_TAKEN`=0, `O_ERROR`=0.
  - `O_COND_READY`=1, since it follows combinationally from IDLE and pending=0.
- Reset mid-response drops the outstanding result with no further `O_TAKEN_VALID`.
- `O_PSR` updates one edge after the write cycle.
- Condition latency is 1 cycle: accept at edge t gives `O_TAKEN_VALID` from t+1.
- Throughput is 1 result per cycle when `I_TAKEN_READY` is held high.
- PSR writes after the accept edge do not alter a held `O_TAKEN`.
- `O_COND_READY` depends combinationally on `I_ALU_VALID` and `I_TAKEN_READY`. `O_TAKEN_VALID`, `O_TAKEN`, `O_PSR` and `O_ERROR` are registered.

## Test plan
- Reset, then `I_PSR_WE`=1 with `I_PSR_WDATA`=5'b01000 -> `O_PSR`=5'b01000 next cycle. Request EQ -> `O_TAKEN_VALID`=1, `O_TAKEN`=1 one cycle later. NE -> 0, UC -> 1, NV -> 0.
- Mask: PSR=5'b11111, `I_ALU_VALID` with status 5'b00000 and mask 5'b00101 -> PSR=5'b11010. Same cycle as `I_PSR_WE` with 5'b00001 -> PSR=5'b00001 (explicit load wins).
- Hazard:
  - Cycle 0: `I_ALU_ISSUE`. Cycle 1: EQ request -> `O_COND_READY`=0.
  - Cycle 2: `I_ALU_VALID` with status Z=1, mask 5'b01000 -> request accepted that cycle.
  - Cycle 3: `O_TAKEN`=1, using the forwarded Z.
- Backpressure: accept LT with PSR=0 -> `O_TAKEN`=1. Hold `I_TAKEN_READY`=0 for 3 cycles while writing N=1 -> `O_TAKEN` stays 1, `O_COND_READY`=0. Then ready=1 with a new GE request -> back-to-back result `O_TAKEN`=1.
- Errors: `I_ALU_VALID` with pending=0 -> `O_ERROR`=1 next cycle and the PSR is still updated. Four issues with no valid -> counter stays 3 and `O_ERROR` stays 1.
- Reset in RESP state -> `O_TAKEN_VALID`=0 and `O_PSR`=`PSR_RESET` immediately, asynchronously.
